flash_sample_sequencer: RTL and testbench

Sequences reads of 16-bit audio samples from the 8-bit parallel flash. Each sample is fetched as two byte reads; FL_ADDR[0] selects the byte. The block tracks the current song and the play position, and applies the remote-derived play/pause, restart, next/prev and speed commands. It sits between the remote keycode decode and the audio DAC serializer, and it is the only master on the flash bus.

---
 rtl/flash_sample_sequencer_if.sv | 26 ++
 rtl/flash_sample_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_flash_sample_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/flash_sample_sequencer_if.sv
// Sample handshake and flash read bus shared by the sequencer and its peers.
//   master (sequencer): in  sample_req, FL_DQ
//                       out sample_data, sample_valid, FL_ADDR, FL_CE_N,
//                           FL_OE_N, FL_WE_N, FL_RST_N
//   slave  (DAC side / flash): the opposite directions
interface flash_sample_sequencer_if;
  logic        sample_req;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic [22:0] FL_ADDR;
  logic [7:0]  FL_DQ;
  logic        FL_CE_N;
  logic        FL_OE_N;
  logic        FL_WE_N;
  logic        FL_RST_N;

  modport master (
    input  sample_req, FL_DQ,
    output sample_data, sample_valid, FL_ADDR, FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N
  );

  modport slave (
    output sample_req, FL_DQ,
    input  sample_data, sample_valid, FL_ADDR, FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N
  );
endinterface

// File: rtl/flash_sample_sequencer.sv
// Fetches 16-bit audio samples as two byte reads from parallel flash, tracks
// song/position and applies remote play/pause, restart, next/prev and speed.
//   CLOCK, Reset       : clock, synchronous active-high reset
//   play_pause, restart, next_song, prev_song : one-cycle command pulses
//   fast, slow         : speed levels
//   playing, song_idx  : play state and current song
//   overrun            : sticky, sample_req seen while a read was busy
//   bus                : sample handshake and flash bus (master side)
module flash_sample_sequencer #(
  parameter int unsigned NUM_SONGS  = 2,
  parameter int unsigned SONG_WORDS = 1048576,
  parameter int unsigned FLASH_WAIT = 4
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic       play_pause,
  input  logic       restart,
  input  logic       next_song,
  input  logic       prev_song,
  input  logic       fast,
  input  logic       slow,
  output logic       playing,
  output logic [1:0] song_idx,
  output logic       overrun,
  flash_sample_sequencer_if.master bus
);
  localparam int unsigned CW = (FLASH_WAIT > 1) ? $clog2(FLASH_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(FLASH_WAIT - 1);
  localparam logic [22:0]   SONG_LEN  = 23'(SONG_WORDS);
  localparam logic [21:0]   SONG_LEN22 = 22'(SONG_WORDS);
  localparam logic [1:0]    LAST_SONG = 2'(NUM_SONGS - 1);

  typedef enum logic [1:0] {IDLE, READ_LO, READ_HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [21:0] ptr, ptr_nxt;
  logic [7:0]  lo_byte, lo_byte_nxt;
  logic        phase, phase_nxt;
  logic        pend_pp, pend_rs, pend_nx, pend_pv;
  logic        pend_pp_nxt, pend_rs_nxt, pend_nx_nxt, pend_pv_nxt;
  logic        playing_nxt, overrun_nxt;
  logic [1:0]  song_nxt;
  logic [15:0] data_q, data_nxt;
  logic        valid_q, valid_nxt;
  logic [22:0] addr_q, addr_nxt;
  logic        strobe_n, strobe_n_nxt;

  logic [21:0] word_addr;
  logic [22:0] step, ptr_sum;

  // Word address of the current position and the speed-dependent advance.
  always_comb begin
    word_addr = (22'(song_idx) * SONG_LEN22) + ptr;
    if (fast && !slow)      step = 23'd2;
    else if (slow && !fast) step = phase ? 23'd1 : 23'd0;
    else                    step = 23'd1;
    ptr_sum = 23'(ptr) + step;
  end

  // Next-state and register updates.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ptr_nxt      = ptr;
    lo_byte_nxt  = lo_byte;
    phase_nxt    = phase;
    playing_nxt  = playing;
    song_nxt     = song_idx;
    overrun_nxt  = overrun;
    data_nxt     = data_q;
    valid_nxt    = 1'b0;
    addr_nxt     = addr_q;
    strobe_n_nxt = strobe_n;
    pend_pp_nxt  = pend_pp | play_pause;
    pend_rs_nxt  = pend_rs | restart;
    pend_nx_nxt  = pend_nx | next_song;
    pend_pv_nxt  = pend_pv | prev_song;

    if (state != IDLE && bus.sample_req) overrun_nxt = 1'b1;

    unique case (state)
      IDLE: begin
        if (bus.sample_req) begin
          if (playing) begin
            addr_nxt     = {word_addr, 1'b0};
            strobe_n_nxt = 1'b0;
            cnt_nxt      = '0;
            state_nxt    = READ_LO;
          end else begin
            data_nxt  = 16'h0000;
            valid_nxt = 1'b1;
          end
        end else begin
          // Apply pending commands; a same-cycle pulse re-arms its flag.
          if (pend_pp) playing_nxt = ~playing;
          if (pend_nx)      song_nxt = (song_idx == LAST_SONG) ? 2'd0 : song_idx + 2'd1;
          else if (pend_pv) song_nxt = (song_idx == 2'd0) ? LAST_SONG : song_idx - 2'd1;
          if (pend_nx || pend_pv || pend_rs) begin
            ptr_nxt   = '0;
            phase_nxt = 1'b0;
          end
          pend_pp_nxt = play_pause;
          pend_rs_nxt = restart;
          pend_nx_nxt = next_song;
          pend_pv_nxt = prev_song;
        end
      end
      READ_LO: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CNT_LAST) begin
          lo_byte_nxt = bus.FL_DQ;
          addr_nxt[0] = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = READ_HI;
        end
      end
      READ_HI: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CNT_LAST) begin
          data_nxt     = {bus.FL_DQ, lo_byte};
          valid_nxt    = 1'b1;
          strobe_n_nxt = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = DONE;
        end
      end
      DONE: begin
        phase_nxt = ~phase;
        // End of song: rewind and stop, song stays selected.
        if (ptr_sum >= SONG_LEN) begin
          ptr_nxt     = '0;
          playing_nxt = 1'b0;
        end else begin
          ptr_nxt = ptr_sum[21:0];
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      lo_byte  <= '0;
      phase    <= 1'b0;
      playing  <= 1'b0;
      song_idx <= 2'd0;
      overrun  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      strobe_n <= 1'b1;
      pend_pp  <= 1'b0;
      pend_rs  <= 1'b0;
      pend_nx  <= 1'b0;
      pend_pv  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      lo_byte  <= lo_byte_nxt;
      phase    <= phase_nxt;
      playing  <= playing_nxt;
      song_idx <= song_nxt;
      overrun  <= overrun_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      addr_q   <= addr_nxt;
      strobe_n <= strobe_n_nxt;
      pend_pp  <= pend_pp_nxt;
      pend_rs  <= pend_rs_nxt;
      pend_nx  <= pend_nx_nxt;
      pend_pv  <= pend_pv_nxt;
    end
  end

  assign bus.sample_data  = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.FL_ADDR      = addr_q;
  assign bus.FL_CE_N      = strobe_n;
  assign bus.FL_OE_N      = strobe_n;
  assign bus.FL_WE_N      = 1'b1;
  assign bus.FL_RST_N     = 1'b1;
endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Bench for flash_sample_sequencer: directed commands and sample requests,
// expected samples queued at issue and checked by a separate monitor.
module tb_flash_sample_sequencer;
  localparam int unsigned NS  = 2;
  localparam int unsigned SW  = 8;
  localparam int unsigned FW  = 4;
  localparam int unsigned LAT = 2 * FW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic play_pause = 1'b0, restart = 1'b0, next_song = 1'b0, prev_song = 1'b0;
  logic fast = 1'b0, slow = 1'b0;
  logic       playing;
  logic [1:0] song_idx;
  logic       overrun;

  flash_sample_sequencer_if bus();

  flash_sample_sequencer #(.NUM_SONGS(NS), .SONG_WORDS(SW), .FLASH_WAIT(FW)) dut (
    .CLOCK(clk), .Reset(rst),
    .play_pause(play_pause), .restart(restart), .next_song(next_song), .prev_song(prev_song),
    .fast(fast), .slow(slow),
    .playing(playing), .song_idx(song_idx), .overrun(overrun),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Flash contents: word w holds {0x12+w, 0x34+w}.
  function automatic logic [15:0] word_val(input int unsigned w);
    logic [7:0] b;
    b = 8'(w);
    return {8'h12 + b, 8'h34 + b};
  endfunction

  function automatic logic [7:0] flash_byte(input logic [22:0] a);
    logic [15:0] v;
    v = word_val(32'(a[22:1]));
    return a[0] ? v[15:8] : v[7:0];
  endfunction

  assign bus.FL_DQ = flash_byte(bus.FL_ADDR);

  typedef struct {
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned strobe_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Monitor: count strobe cycles and compare every presented sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus.FL_CE_N && !bus.FL_OE_N) strobe_cnt++;
      if (bus.sample_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got sample_valid=1 data %0h, required none", bus.sample_data);
        end else begin
          e = q.pop_front();
          chk("sample_data", 32'(bus.sample_data), 32'(e.data));
          chk("valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic req_exp(input logic [15:0] d, input int unsigned lat);
    @(posedge clk); #1;
    bus.sample_req = 1'b1;
    q.push_back('{data: d, cyc: cyc + lat});
    @(posedge clk); #1;
    bus.sample_req = 1'b0;
  endtask

  task automatic req_raw();
    @(posedge clk); #1 bus.sample_req = 1'b1;
    @(posedge clk); #1 bus.sample_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    chk("drain_timeout", q.size(), 0);
    q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic play_word(input int unsigned w);
    req_exp(word_val(w), LAT);
    drain();
  endtask

  task automatic cmd(input logic pp, input logic rs, input logic nx, input logic pv);
    @(posedge clk); #1;
    play_pause = pp; restart = rs; next_song = nx; prev_song = pv;
    @(posedge clk); #1;
    play_pause = 0; restart = 0; next_song = 0; prev_song = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_playing"}, 32'(playing), 0);
    chk({tag, "_song"}, 32'(song_idx), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_valid"}, 32'(bus.sample_valid), 0);
    chk({tag, "_data"}, 32'(bus.sample_data), 0);
    chk({tag, "_addr"}, 32'(bus.FL_ADDR), 0);
    chk({tag, "_ce_n"}, 32'(bus.FL_CE_N), 1);
    chk({tag, "_oe_n"}, 32'(bus.FL_OE_N), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    bus.sample_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    chk("we_n", 32'(bus.FL_WE_N), 1);
    chk("rst_n", 32'(bus.FL_RST_N), 1);

    // Paused request: zero sample next cycle, no flash access.
    strobe_cnt = 0;
    req_exp(16'h0000, 1);
    drain();
    chk("paused_strobe", strobe_cnt, 0);

    cmd(1, 0, 0, 0);
    chk("playing_on", 32'(playing), 1);

    strobe_cnt = 0;
    play_word(0);
    chk("read_strobe_cycles", strobe_cnt, 2 * FW);
    play_word(1);

    // Fast: words 0,2,4.
    cmd(0, 1, 0, 0);
    fast = 1'b1;
    play_word(0); play_word(2); play_word(4);
    fast = 1'b0;

    // Slow: each word twice.
    cmd(0, 1, 0, 0);
    slow = 1'b1;
    play_word(0); play_word(0); play_word(1); play_word(1);
    // Both levels act as normal speed.
    fast = 1'b1;
    play_word(2);
    fast = 1'b0; slow = 1'b0;

    // Run to end of song 0.
    for (int w = 3; w < SW; w++) play_word(w);
    @(negedge clk);
    chk("end_playing", 32'(playing), 0);
    chk("end_song", 32'(song_idx), 0);
    req_exp(16'h0000, 1);
    drain();

    // next_song during READ_HI: current sample finishes from song 0.
    cmd(1, 0, 0, 0);
    play_word(0);
    req_exp(word_val(1), LAT);
    repeat (5) @(posedge clk);
    #1 next_song = 1'b1;
    @(posedge clk); #1 next_song = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("next_song_idx", 32'(song_idx), 1);
    chk("addr_hold", 32'(bus.FL_ADDR), 3);
    play_word(SW);
    chk("song1_addr", 32'(bus.FL_ADDR), 2 * SW + 1);

    cmd(0, 0, 0, 1);
    chk("prev_to_0", 32'(song_idx), 0);
    cmd(0, 0, 0, 1);
    chk("prev_wrap", 32'(song_idx), NS - 1);

    // All pending at once: next wins, play_pause toggles too.
    cmd(1, 1, 1, 1);
    chk("prio_song", 32'(song_idx), 0);
    chk("prio_playing", 32'(playing), 0);

    // Overrun from a request during READ_LO.
    cmd(1, 0, 0, 0);
    req_exp(word_val(0), LAT);
    @(posedge clk); #1 bus.sample_req = 1'b1;
    @(posedge clk); #1 bus.sample_req = 1'b0;
    drain();
    chk("overrun_set", 32'(overrun), 1);
    play_word(1);
    chk("overrun_sticky", 32'(overrun), 1);

    // Reset during READ_HI: no sample, everything back to reset values.
    req_raw();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreset");
    repeat (12) @(posedge clk);
    req_exp(16'h0000, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
